// File: rtl/seq_det_pkg.sv
// -----------------------------------------------------------------------------
// seq_det_pkg
// Shared definitions for the parametrised sequence recognizer.
//   - DEFAULT_PATTERN : reset pattern for the default SYM_W=2 / LEN=4 build
//                       (oldest symbol in the most-significant slot).
//   - fill_w()        : width of the history fill counter (0..LEN-1).
//   - sym_slot()      : extracts symbol slot idx (0 = least significant)
//                       from a packed symbol vector.
// No ports (package). Optional feature macro used elsewhere:
// SEQ_DET_MATCH_CNT_EN.
// -----------------------------------------------------------------------------
package seq_det_pkg;

    localparam int DEF_SYM_W = 2;
    localparam int DEF_LEN   = 4;

    localparam logic [DEF_LEN*DEF_SYM_W-1:0] DEFAULT_PATTERN = 8'b00_01_00_01;

    // Upper bounds for the generic slot helper.
    localparam int MAX_VEC_W = 256;
    localparam int MAX_SYM_W = 32;

    // The fill counter holds 0..len-1, so clog2(len) bits suffice (len >= 2).
    function automatic int fill_w(input int len);
        return (len <= 2) ? 1 : $clog2(len);
    endfunction

    function automatic logic [MAX_SYM_W-1:0] sym_slot(
        input logic [MAX_VEC_W-1:0] vec,
        input int unsigned          idx,
        input int unsigned          sym_w
    );
        logic [MAX_VEC_W-1:0] mask;
        mask = (MAX_VEC_W'(1) << sym_w) - MAX_VEC_W'(1);
        return MAX_SYM_W'((vec >> (idx * sym_w)) & mask);
    endfunction

endpackage

// File: rtl/seq_det_sigma_omega.sv
// -----------------------------------------------------------------------------
// seq_det_sigma_omega
// Purely combinational next-state (sigma) and output (omega) logic of the
// sequence recognizer.
// Ports:
//   pat_i      : current pattern register
//   hist_i     : last LEN-1 accepted symbols, newest in the LS slot
//   fill_i     : number of valid history symbols (saturates at LEN-1)
//   sym_i      : current input symbol
//   valid_i    : symbol qualifier
//   overlap_i  : 1 = overlapping matches allowed
//   pat_we_i   : pattern load strobe
//   pat_in_i   : pattern to load
//   match_o    : Mealy match flag
//   pat_d_o, hist_d_o, fill_d_o : next-state values
// -----------------------------------------------------------------------------
module seq_det_sigma_omega
    import seq_det_pkg::*;
#(
    parameter int SYM_W  = 2,
    parameter int LEN    = 4,
    parameter int FILL_W = fill_w(LEN)
) (
    input  logic [LEN*SYM_W-1:0]     pat_i,
    input  logic [(LEN-1)*SYM_W-1:0] hist_i,
    input  logic [FILL_W-1:0]        fill_i,
    input  logic [SYM_W-1:0]         sym_i,
    input  logic                     valid_i,
    input  logic                     overlap_i,
    input  logic                     pat_we_i,
    input  logic [LEN*SYM_W-1:0]     pat_in_i,
    output logic                     match_o,
    output logic [LEN*SYM_W-1:0]     pat_d_o,
    output logic [(LEN-1)*SYM_W-1:0] hist_d_o,
    output logic [FILL_W-1:0]        fill_d_o
);

    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(LEN - 1);

    logic [LEN*SYM_W-1:0] cand;
    logic                 full;

    assign cand = {hist_i, sym_i};
    assign full = (fill_i == FILL_MAX);

    always_comb begin
        // A load cycle never reports a match: the old pattern is being replaced.
        match_o  = valid_i & ~pat_we_i & full & (cand == pat_i);
        pat_d_o  = pat_i;
        hist_d_o = hist_i;
        fill_d_o = fill_i;
        if (pat_we_i) begin
            pat_d_o  = pat_in_i;
            hist_d_o = '0;
            fill_d_o = '0;
        end else if (valid_i) begin
            // Drop the oldest symbol of the candidate window.
            hist_d_o = cand[(LEN-1)*SYM_W-1:0];
            if (match_o && !overlap_i) begin
                // Non-overlapping: the matched symbols cannot start a new match.
                fill_d_o = '0;
            end else if (!full) begin
                fill_d_o = fill_i + 1'b1;
            end
        end
    end

endmodule

// File: rtl/seq_det_param.sv
// -----------------------------------------------------------------------------
// seq_det_param
// Parametrised Mealy sequence recognizer. Flags each occurrence of a
// runtime-loadable LEN-symbol pattern on the cycle its last symbol arrives.
// Ports:
//   clock    : rising-edge clock
//   reset    : asynchronous, active-high reset
//   in       : current input symbol (SYM_W bits)
//   in_valid : symbol qualifier; invalid cycles are transparent gaps
//   overlap  : 1 = overlapping matches, 0 = non-overlapping
//   pat_we   : pattern load strobe (clears history)
//   pat_in   : new pattern, oldest symbol in MS slot
//   cnt_clr  : synchronous clear of the match counter
//   out      : match flag (combinational)
//   cnt      : saturating match count
// Optional feature: define SEQ_DET_MATCH_CNT_EN to build the match counter;
// otherwise cnt is tied to zero and cnt_clr is ignored.
// -----------------------------------------------------------------------------
module seq_det_param
    import seq_det_pkg::*;
#(
    parameter int                   SYM_W   = 2,
    parameter int                   LEN     = 4,
    parameter logic [LEN*SYM_W-1:0] PATTERN = DEFAULT_PATTERN,
    parameter int                   CNT_W   = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [SYM_W-1:0]     in,
    input  logic                 in_valid,
    input  logic                 overlap,
    input  logic                 pat_we,
    input  logic [LEN*SYM_W-1:0] pat_in,
    input  logic                 cnt_clr,
    output logic                 out,
    output logic [CNT_W-1:0]     cnt
);

    localparam int FILL_W = fill_w(LEN);

    logic [LEN*SYM_W-1:0]     pat_q,  pat_d;
    logic [(LEN-1)*SYM_W-1:0] hist_q, hist_d;
    logic [FILL_W-1:0]        fill_q, fill_d;

    // While reset is held, fill_q is 0, which alone forces out low.
    seq_det_sigma_omega #(
        .SYM_W  (SYM_W),
        .LEN    (LEN),
        .FILL_W (FILL_W)
    ) u_sigma_omega (
        .pat_i     (pat_q),
        .hist_i    (hist_q),
        .fill_i    (fill_q),
        .sym_i     (in),
        .valid_i   (in_valid),
        .overlap_i (overlap),
        .pat_we_i  (pat_we),
        .pat_in_i  (pat_in),
        .match_o   (out),
        .pat_d_o   (pat_d),
        .hist_d_o  (hist_d),
        .fill_d_o  (fill_d)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pat_q  <= PATTERN;
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            pat_q  <= pat_d;
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

`ifdef SEQ_DET_MATCH_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (out && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign cnt            = '0;
`endif

endmodule

// File: tb/tb_seq_det_param.sv
// -----------------------------------------------------------------------------
// tb_seq_det_param
// Self-checking bench for seq_det_param with SYM_W=2, LEN=3, CNT_W=2 and a
// reset pattern of 1,1,1. Expected match flags are queued as stimulus is
// driven and popped when the output is sampled on the falling edge.
// Counter expectations follow SEQ_DET_MATCH_CNT_EN (zero when undefined).
// -----------------------------------------------------------------------------
module tb_seq_det_param;

    localparam logic [5:0] P111 = 6'b01_01_01;
    localparam logic [5:0] P012 = 6'b00_01_10;
    localparam logic [5:0] P222 = 6'b10_10_10;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] sym = 2'd0;
    logic       in_valid = 1'b0;
    logic       overlap = 1'b1;
    logic       pat_we = 1'b0;
    logic [5:0] pat_in = 6'd0;
    logic       cnt_clr = 1'b0;
    logic       out;
    logic [1:0] cnt;

    logic       exp_q[$];
    logic [1:0] exp_cnt = 2'd0;
    logic [1:0] exp_cnt_nxt = 2'd0;
    int         errors = 0;
    int         checks = 0;

    seq_det_param #(
        .SYM_W   (2),
        .LEN     (3),
        .PATTERN (P111),
        .CNT_W   (2)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .in       (sym),
        .in_valid (in_valid),
        .overlap  (overlap),
        .pat_we   (pat_we),
        .pat_in   (pat_in),
        .cnt_clr  (cnt_clr),
        .out      (out),
        .cnt      (cnt)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    // Drive one cycle of stimulus just after the rising edge and queue the
    // expected match flag for that cycle.
    task automatic drive(input logic [1:0] s, input logic v, input logic we,
                         input logic [5:0] p, input logic clr, input logic e);
        @(posedge clock);
        #1;
        exp_cnt  = exp_cnt_nxt;
        sym      = s;
        in_valid = v;
        pat_we   = we;
        pat_in   = p;
        cnt_clr  = clr;
        exp_q.push_back(e);
`ifdef SEQ_DET_MATCH_CNT_EN
        if (clr) exp_cnt_nxt = 2'd0;
        else if (e && exp_cnt != 2'd3) exp_cnt_nxt = exp_cnt + 2'd1;
`endif
    endtask

    task automatic test_reset();
        logic e;
        #2;
        checks++;
        if (out !== 1'b0) begin errors++; $display("FAIL reset_out got=%b exp=0", out); end
        checks++;
        if (cnt !== 2'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", cnt); end
        sym = 2'd1; in_valid = 1'b1;
        #1;
        e = 1'b0;
        checks++;
        if (out !== e) begin errors++; $display("FAIL reset_out_valid got=%b exp=%b", out, e); end
        in_valid = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        exp_cnt = 2'd0; exp_cnt_nxt = 2'd0;
    endtask

    task automatic test_overlap();
        logic ex[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic e;
        overlap = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(2'd1, 1'b1, 1'b0, 6'd0, 1'b0, ex[i]);
            @(negedge clock);
            e = exp_q.pop_front();
            checks++;
            if (out !== e) begin errors++; $display("FAIL overlap[%0d] got=%b exp=%b", i, out, e); end
        end
        drive(2'd0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
        @(negedge clock);
        e = exp_q.pop_front();
        checks++;
        if (cnt !== exp_cnt) begin errors++; $display("FAIL overlap_cnt got=%0d exp=%0d", cnt, exp_cnt); end
    endtask

    task automatic test_nonoverlap();
        logic ex[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic e;
        overlap = 1'b0;
        for (int i = 0; i < 7; i++) begin
            if (i == 0) drive(2'd1, 1'b0, 1'b1, P111, 1'b1, ex[i]);
            else        drive(2'd1, 1'b1, 1'b0, 6'd0, 1'b0, ex[i]);
            @(negedge clock);
            e = exp_q.pop_front();
            checks++;
            if (out !== e) begin errors++; $display("FAIL nonoverlap[%0d] got=%b exp=%b", i, out, e); end
        end
        drive(2'd0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
        @(negedge clock);
        e = exp_q.pop_front();
        checks++;
        if (cnt !== exp_cnt) begin errors++; $display("FAIL nonoverlap_cnt got=%0d exp=%0d", cnt, exp_cnt); end
    endtask

    task automatic test_gap();
        logic [1:0] s[7]  = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2};
        logic       v[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        logic       ex[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic e;
        overlap = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if (i == 0) drive(s[i], v[i], 1'b1, P012, 1'b1, ex[i]);
            else        drive(s[i], v[i], 1'b0, 6'd0, 1'b0, ex[i]);
            @(negedge clock);
            e = exp_q.pop_front();
            checks++;
            if (out !== e) begin errors++; $display("FAIL gap[%0d] got=%b exp=%b", i, out, e); end
        end
    endtask

    task automatic test_load();
        logic [1:0] s[6]  = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2};
        logic       w[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic       ex[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic e;
        overlap = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(s[i], 1'b1, w[i], P222, 1'b0, ex[i]);
            @(negedge clock);
            e = exp_q.pop_front();
            checks++;
            if (out !== e) begin errors++; $display("FAIL load[%0d] got=%b exp=%b", i, out, e); end
        end
    endtask

    task automatic test_reset_mid();
        logic ex[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic e;
        overlap = 1'b1;
        // Restore the reset pattern 1,1,1.
        drive(2'd0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
        @(negedge clock);
        e = exp_q.pop_front();
        #1 reset = 1'b1;
        #1 reset = 1'b0;
        exp_cnt = 2'd0; exp_cnt_nxt = 2'd0;
        for (int i = 0; i < 2; i++) begin
            drive(2'd1, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
            @(negedge clock);
            e = exp_q.pop_front();
            checks++;
            if (out !== e) begin errors++; $display("FAIL rstmid_pre[%0d] got=%b exp=%b", i, out, e); end
        end
        drive(2'd0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
        @(negedge clock);
        e = exp_q.pop_front();
        // Asynchronous reset in the middle of the idle cycle, with a symbol
        // that would complete the pattern presented while reset is high.
        #2 reset = 1'b1;
        sym = 2'd1; in_valid = 1'b1;
        #1;
        checks++;
        if (out !== 1'b0) begin errors++; $display("FAIL rstmid_out got=%b exp=0", out); end
        checks++;
        if (cnt !== 2'd0) begin errors++; $display("FAIL rstmid_cnt got=%0d exp=0", cnt); end
        in_valid = 1'b0;
        reset = 1'b0;
        exp_cnt = 2'd0; exp_cnt_nxt = 2'd0;
        for (int i = 2; i < 6; i++) begin
            if (i == 2) drive(2'd0, 1'b0, 1'b0, 6'd0, 1'b0, ex[i]);
            else        drive(2'd1, 1'b1, 1'b0, 6'd0, 1'b0, ex[i]);
            @(negedge clock);
            e = exp_q.pop_front();
            checks++;
            if (out !== e) begin errors++; $display("FAIL rstmid_post[%0d] got=%b exp=%b", i, out, e); end
        end
    endtask

    task automatic test_cnt_sat();
        logic e;
        overlap = 1'b1;
        drive(2'd0, 1'b0, 1'b0, 6'd0, 1'b1, 1'b0);
        @(negedge clock);
        e = exp_q.pop_front();
        for (int i = 0; i < 5; i++) begin
            drive(2'd1, 1'b1, 1'b0, 6'd0, 1'b0, 1'b1);
            @(negedge clock);
            e = exp_q.pop_front();
            checks++;
            if (out !== e) begin errors++; $display("FAIL cntsat[%0d] got=%b exp=%b", i, out, e); end
        end
        drive(2'd0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
        @(negedge clock);
        e = exp_q.pop_front();
        checks++;
        if (cnt !== exp_cnt) begin errors++; $display("FAIL cnt_saturate got=%0d exp=%0d", cnt, exp_cnt); end
        drive(2'd1, 1'b1, 1'b0, 6'd0, 1'b1, 1'b1);
        @(negedge clock);
        e = exp_q.pop_front();
        checks++;
        if (out !== e) begin errors++; $display("FAIL cntclr_match got=%b exp=%b", out, e); end
        drive(2'd0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
        @(negedge clock);
        e = exp_q.pop_front();
        checks++;
        if (cnt !== exp_cnt) begin errors++; $display("FAIL cnt_clear got=%0d exp=%0d", cnt, exp_cnt); end
    endtask

    // Random stream against a window model of the accepted symbols.
    task automatic test_random();
        int         win[$];
        logic [1:0] s;
        logic       v, ov, e;
        drive(2'd0, 1'b0, 1'b1, P111, 1'b1, 1'b0);
        @(negedge clock);
        e = exp_q.pop_front();
        win.delete();
        for (int i = 0; i < 150; i++) begin
            s  = ($urandom_range(0, 3) == 0) ? 2'd0 : 2'd1;
            v  = ($urandom_range(0, 3) != 0);
            ov = $urandom_range(0, 1) == 1;
            e  = 1'b0;
            if (v) begin
                win.push_back(int'(s));
                if (win.size() > 3) void'(win.pop_front());
                e = (win.size() == 3) && (win[0] == 1) && (win[1] == 1) && (win[2] == 1);
                if (e && !ov) win.delete();
            end
            drive(s, v, 1'b0, 6'd0, 1'b0, e);
            overlap = ov;
            @(negedge clock);
            e = exp_q.pop_front();
            checks++;
            if (out !== e) begin errors++; $display("FAIL random_out[%0d] got=%b exp=%b", i, out, e); end
            checks++;
            if (cnt !== exp_cnt) begin errors++; $display("FAIL random_cnt[%0d] got=%0d exp=%0d", i, cnt, exp_cnt); end
        end
    endtask

    initial begin
        test_reset();
        test_overlap();
        test_nonoverlap();
        test_gap();
        test_load();
        test_reset_mid();
        test_cnt_sat();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
